ram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the team's single-port synchronous RAM (cs/rw/address/data_in/data_out, 1-cycle registered read). Each requester (A, B) issues one read or write at a time through a req/ack handshake. The block serializes the accesses, drives the RAM control pins, and captures read data for the winning requester.

---
 rtl/ram_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port synchronous RAM with 1-cycle read.
// Optional out-of-range address trapping is enabled by defining ARB_ADDR_CHECK_EN.
module ram_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_rw,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_rw,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              ram_cs,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

`ifdef ARB_ADDR_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
`endif

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_bad
        $error("ram_port_arbiter: DEPTH does not fit the address space");
    end

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_grant_q, last_grant_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic                a_err_q, a_err_d;
    logic                b_err_q, b_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic                any_req_s;
    logic                sel_b_s;
    logic                win_rw_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [DATA_W-1:0]   win_wdata_s;
    logic                bad_addr_s;

    // Round-robin pick of the winner and mux of its request fields
    always_comb begin
        any_req_s = a_req | b_req;
        if (a_req && b_req) begin
            sel_b_s = ~last_grant_q;
        end else if (b_req) begin
            sel_b_s = GRANT_B;
        end else begin
            sel_b_s = GRANT_A;
        end
        if (sel_b_s) begin
            win_rw_s    = b_rw;
            win_addr_s  = b_addr;
            win_wdata_s = b_wdata;
        end else begin
            win_rw_s    = a_rw;
            win_addr_s  = a_addr;
            win_wdata_s = a_wdata;
        end
        bad_addr_s = 1'b0;
`ifdef ARB_ADDR_CHECK_EN
        if ({1'b0, win_addr_s} >= DEPTH_C) begin
            bad_addr_s = 1'b1;
        end else begin
            bad_addr_s = 1'b0;
        end
`endif
    end

    // Sequencer next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        ram_cs_d     = 1'b0;
        ram_rw_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_err_d      = 1'b0;
        b_err_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    winner_d     = sel_b_s;
                    last_grant_d = sel_b_s;
                    if (bad_addr_s) begin
                        // Trapped access: complete immediately without touching the RAM
                        state_d = DONE;
                        if (sel_b_s) begin
                            b_ack_d = 1'b1;
                            b_err_d = 1'b1;
                            if (!win_rw_s) begin
                                b_rdata_d = {DATA_W{1'b0}};
                            end else begin
                                b_rdata_d = b_rdata_q;
                            end
                        end else begin
                            a_ack_d = 1'b1;
                            a_err_d = 1'b1;
                            if (!win_rw_s) begin
                                a_rdata_d = {DATA_W{1'b0}};
                            end else begin
                                a_rdata_d = a_rdata_q;
                            end
                        end
                    end else begin
                        state_d     = ISSUE;
                        ram_cs_d    = 1'b1;
                        ram_rw_d    = win_rw_s;
                        ram_addr_d  = win_addr_s;
                        ram_wdata_d = win_wdata_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (ram_rw_q) begin
                    state_d = DONE;
                    if (winner_q) begin
                        b_ack_d = 1'b1;
                    end else begin
                        a_ack_d = 1'b1;
                    end
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                state_d = DONE;
                if (winner_q) begin
                    b_ack_d   = 1'b1;
                    b_rdata_d = ram_rdata;
                end else begin
                    a_ack_d   = 1'b1;
                    a_rdata_d = ram_rdata;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to B so A wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            winner_q     <= GRANT_A;
            last_grant_q <= GRANT_B;
            ram_cs_q     <= 1'b0;
            ram_rw_q     <= 1'b0;
            ram_addr_q   <= {ADDR_W{1'b0}};
            ram_wdata_q  <= {DATA_W{1'b0}};
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            a_rdata_q    <= {DATA_W{1'b0}};
            b_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            ram_cs_q     <= ram_cs_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_err_q      <= a_err_d;
            b_err_q      <= b_err_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    assign ram_cs    = ram_cs_q;
    assign ram_rw    = ram_rw_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural single-port RAM.
// Covers either build of ARB_ADDR_CHECK_EN.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, a_rw, b_req, b_rw;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_ack, a_err, b_ack, b_err;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              ram_cs, ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rw) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req = 1'b0; a_rw = 1'b0; a_addr = 6'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_rw = 1'b0; b_addr = 6'd0; b_wdata = 8'h00;
        tick;
        tick;
        checks++;
        if ({a_ack, b_ack, a_err, b_err, ram_cs, ram_rw, ram_addr, ram_wdata, a_rdata, b_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {a_ack, b_ack, a_err, b_err, ram_cs, ram_rw, ram_addr, ram_wdata, a_rdata, b_rdata});
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        a_req = 1'b1; a_rw = 1'b1; a_addr = 6'd3; a_wdata = 8'h5A;
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 6'd3 || ram_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL issue_write got cs=%b rw=%b addr=%0d wd=%h required 1 1 3 5a", ram_cs, ram_rw, ram_addr, ram_wdata);
        end
        checks++;
        if (a_ack !== 1'b0) begin
            errors++;
            $display("FAIL a_ack_early got %b required 0", a_ack);
        end
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL a_write_ack got ack=%b err=%b cs=%b required 1 0 0", a_ack, a_err, ram_cs);
        end
        tick;
        a_req = 1'b0;
        b_req = 1'b1; b_rw = 1'b0; b_addr = 6'd3;
        checks++;
        if (ram_cs !== 1'b0 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_write got cs=%b a_ack=%b required 0 0", ram_cs, a_ack);
        end
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 6'd3) begin
            errors++;
            $display("FAIL issue_read got cs=%b rw=%b addr=%0d required 1 0 3", ram_cs, ram_rw, ram_addr);
        end
        tick;
        checks++;
        if (b_ack !== 1'b0 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL rwait got b_ack=%b cs=%b required 0 0", b_ack, ram_cs);
        end
        tick;
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 8'h5A || a_ack !== 1'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL b_read_ack got ack=%b rdata=%h a_ack=%b err=%b required 1 5a 0 0", b_ack, b_rdata, a_ack, b_err);
        end
        tick;
        b_req = 1'b0;
    endtask

    task automatic test_simultaneous;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        a_req = 1'b1; a_rw = 1'b1; a_addr = 6'd1; a_wdata = 8'h11;
        b_req = 1'b1; b_rw = 1'b0; b_addr = 6'd1;
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 6'd1) begin
            errors++;
            $display("FAIL tie_a_first got cs=%b rw=%b addr=%0d required 1 1 1", ram_cs, ram_rw, ram_addr);
        end
        tick;
        checks++;
        if (a_ack !== 1'b1 || b_ack !== 1'b0) begin
            errors++;
            $display("FAIL tie_a_ack got a=%b b=%b required 1 0", a_ack, b_ack);
        end
        tick;
        a_req = 1'b0;
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 6'd1) begin
            errors++;
            $display("FAIL tie_b_issue got cs=%b rw=%b addr=%0d required 1 0 1", ram_cs, ram_rw, ram_addr);
        end
        tick;
        tick;
        checks++;
        if (b_ack !== 1'b1 || a_ack !== 1'b0 || b_rdata !== 8'h11) begin
            errors++;
            $display("FAIL tie_b_read got b_ack=%b a_ack=%b rdata=%h required 1 0 11", b_ack, a_ack, b_rdata);
        end
        tick;
        b_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        int na = 0;
        int nb = 0;
        int cyc = 0;
        logic exp_b = 1'b0;
        logic a_upd = 1'b0;
        logic b_upd = 1'b0;
        logic prev_cs = 1'b0;
        logic [DATA_W-1:0] exp_rd;
        a_req = 1'b1; a_rw = 1'b1; a_addr = 6'd0; a_wdata = 8'hA0;
        b_req = 1'b1; b_rw = 1'b0; b_addr = 6'd0;
        while ((na < 4 || nb < 4) && cyc < 200) begin
            tick;
            cyc++;
            if (a_upd) begin
                a_upd = 1'b0;
                na++;
                if (na < 4) begin
                    a_addr = 6'(na);
                    a_wdata = 8'hA0 + 8'(na);
                end else begin
                    a_req = 1'b0;
                end
            end
            if (b_upd) begin
                b_upd = 1'b0;
                nb++;
                if (nb < 4) b_addr = 6'(nb);
                else        b_req = 1'b0;
            end
            if (ram_cs) begin
                checks++;
                if (prev_cs !== 1'b0) begin
                    errors++;
                    $display("FAIL cs_width got two consecutive cs cycles at cycle %0d required one", cyc);
                end
            end
            prev_cs = ram_cs;
            if (a_ack) begin
                checks++;
                if (exp_b !== 1'b0 || b_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL grant_order got A (b_ack=%b) required %s", b_ack, exp_b ? "B" : "A alone");
                end
                exp_b = 1'b1;
                a_upd = 1'b1;
            end
            if (b_ack) begin
                exp_rd = 8'hA0 + 8'(nb);
                checks++;
                if (exp_b !== 1'b1 || a_ack !== 1'b0 || b_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL grant_order_b got B rdata=%h a_ack=%b required B after A rdata=%h", b_rdata, a_ack, exp_rd);
                end
                exp_b = 1'b0;
                b_upd = 1'b1;
            end
        end
        checks++;
        if (na != 4 || nb != 4) begin
            errors++;
            $display("FAIL back_to_back_count got a=%0d b=%0d required 4 4", na, nb);
        end
    endtask

    task automatic test_reset_mid;
        b_req = 1'b1; b_rw = 1'b0; b_addr = 6'd2;
        tick;
        tick;
        rst = 1'b1;
        tick;
        checks++;
        if ({a_ack, b_ack, a_err, b_err, ram_cs, ram_rw, ram_addr, ram_wdata, a_rdata, b_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h required 0",
                     {a_ack, b_ack, a_err, b_err, ram_cs, ram_rw, ram_addr, ram_wdata, a_rdata, b_rdata});
        end
        rst = 1'b0;
        tick;
        checks++;
        if (b_ack !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 6'd2) begin
            errors++;
            $display("FAIL mid_reset_reissue got b_ack=%b cs=%b addr=%0d required 0 1 2", b_ack, ram_cs, ram_addr);
        end
        tick;
        tick;
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 8'hA2) begin
            errors++;
            $display("FAIL mid_reset_complete got ack=%b rdata=%h required 1 a2", b_ack, b_rdata);
        end
        tick;
        b_req = 1'b0;
    endtask

`ifdef ARB_ADDR_CHECK_EN
    task automatic test_addr_check;
        a_req = 1'b1; a_rw = 1'b0; a_addr = 6'd3;
        tick;
        tick;
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_rdata !== 8'hA3) begin
            errors++;
            $display("FAIL pre_read got ack=%b rdata=%h required 1 a3", a_ack, a_rdata);
        end
        tick;
        a_addr = 6'd6;
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b1 || a_rdata !== 8'h00 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr got ack=%b err=%b rdata=%h cs=%b required 1 1 00 0", a_ack, a_err, a_rdata, ram_cs);
        end
        tick;
        a_rw = 1'b1; a_addr = 6'd5; a_wdata = 8'h55;
        checks++;
        if (ram_cs !== 1'b0 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL bad_addr_idle got cs=%b ack=%b required 0 0", ram_cs, a_ack);
        end
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 6'd5) begin
            errors++;
            $display("FAIL edge_write_issue got cs=%b rw=%b addr=%0d required 1 1 5", ram_cs, ram_rw, ram_addr);
        end
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL edge_write_ack got ack=%b err=%b required 1 0", a_ack, a_err);
        end
        tick;
        a_req = 1'b0;
    endtask
`else
    task automatic test_addr_passthru;
        a_req = 1'b1; a_rw = 1'b1; a_addr = 6'd6; a_wdata = 8'h66;
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 6'd6) begin
            errors++;
            $display("FAIL pass_write_issue got cs=%b rw=%b addr=%0d required 1 1 6", ram_cs, ram_rw, ram_addr);
        end
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL pass_write_ack got ack=%b err=%b required 1 0", a_ack, a_err);
        end
        tick;
        a_rw = 1'b0;
        tick;
        checks++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 6'd6) begin
            errors++;
            $display("FAIL pass_read_issue got cs=%b rw=%b addr=%0d required 1 0 6", ram_cs, ram_rw, ram_addr);
        end
        tick;
        tick;
        checks++;
        if (a_ack !== 1'b1 || a_err !== 1'b0 || a_rdata !== 8'h66) begin
            errors++;
            $display("FAIL pass_read_ack got ack=%b err=%b rdata=%h required 1 0 66", a_ack, a_err, a_rdata);
        end
        tick;
        a_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_write_read;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid;
`ifdef ARB_ADDR_CHECK_EN
        test_addr_check;
`else
        test_addr_passthru;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
